// File: rtl/my_arbiter_8_way_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// The timeout pulse exists only when MY_ARBITER_8_WAY_TIMEOUT_EN is defined.
interface my_arbiter_8_way_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       any_req;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
    logic       timeout;

    modport master (output req, done, input grant, grant_id, busy, any_req, timeout);
    modport slave  (input req, done, output grant, grant_id, busy, any_req, timeout);
`else
    modport master (output req, done, input grant, grant_id, busy, any_req);
    modport slave  (input req, done, output grant, grant_id, busy, any_req);
`endif
endinterface

// File: rtl/my_arbiter_8_way.sv
// Round-robin arbiter: one shared resource, eight requesters, grant held until done/withdraw.
// MY_ARBITER_8_WAY_TIMEOUT_EN adds a tenure counter that force-releases after TIMEOUT_CYCLES.
module my_arbiter_8_way #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    my_arbiter_8_way_if.slave     bus
);
    localparam int NUM_LANES = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] id_q, id_d;
    logic [2:0] ptr_q, ptr_d;
    logic [NUM_LANES-1:0] rot;
    logic [2:0] win;
    logic       normal_rel;
    logic       expire;

    assign bus.any_req = |bus.req;

    // Request vector rotated so that rot[0] is the requester at ptr.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_rot
        assign rot[k] = bus.req[3'(ptr_q + 3'(k))];
    end

    always_comb begin
        win = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--)
            if (rot[k]) win = ptr_q + 3'(k);
    end

    assign normal_rel = bus.done || !bus.req[id_q];

`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    assign expire      = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign bus.timeout = to_q;
`else
    // Without the counter a grant never expires; the parameter is inert.
    assign expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.any_req) begin
                    state_d = GRANT;
                    grant_d = 8'b1 << win;
                    id_d    = win;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (normal_rel || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = id_q + 3'd1;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
                    to_d    = expire && !normal_rel;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
`ifdef MY_ARBITER_8_WAY_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = (state_q == GRANT);
endmodule

// File: doc/my_arbiter_8_way.md
# my_arbiter_8_way

Round-robin arbiter granting one shared resource to up to eight requesters. Uses an 8-way OR reduction of the request vector to detect any pending request, then selects a winner fairly starting after the last owner. Holds the grant until the owner signals completion or withdraws its request. Sits in front of any single-ported datapath element (ALU, memory port, bus) that multiple clients must share.

## Interface

- `TIMEOUT_CYCLES`, default 16: max cycles a grant may be held; used only when `MY_ARBITER_8_WAY_TIMEOUT_EN` is defined; legal range 2..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  8  request vector; bit i = requester i wants the resource.
- `done`  in  1  current owner finished; sampled only while busy.
- `grant`  out  8  one-hot grant; all-zero when idle.
- `grant_id`  out  3  binary index of current owner; valid when `busy`=1.
- `busy`  out  1  a grant is active.
- `any_req`  out  1  combinational OR of all 8 `req` bits.
- `timeout`  out  1  one-cycle pulse when a grant is force-released; exists only with `MY_ARBITER_8_WAY_TIMEOUT_EN`.

## Operation

- Reset (`rst_n`=0, async): `grant`=8'b0, `grant_id`=0, `busy`=0, `timeout`=0, round-robin pointer `ptr`=0, state IDLE. `any_req` still follows `req`.
- States: IDLE, GRANT.
- IDLE: if `any_req`=1 at a rising edge, winner = first set `req` bit scanning i = ptr, ptr+1, …, ptr+7 (mod 8, wrap 7→0). Register `grant`=1<<winner, `grant_id`=winner, `busy`=1; go GRANT. If `any_req`=0, stay IDLE.
- GRANT: release at a rising edge when `done`=1 OR `req[grant_id]`=0. On release: `grant`=0, `busy`=0, `ptr`=(grant_id+1) mod 8 (3-bit wrap), go IDLE. Otherwise hold all outputs unchanged.
- `done` and owner `req` drop in same cycle: single release, no double pointer advance.
- `done` while IDLE: ignored.
- Requests from non-owners during GRANT: ignored until next IDLE arbitration; no preemption.
- Exactly one idle cycle between consecutive grants (GRANT→IDLE→GRANT).
- `grant` always one-hot or zero; `grant[grant_id]`=`busy`.
- Reset mid-grant: outputs clear immediately (asynchronous), pointer returns to 0; owner must re-request.

## Timing

- `req` asserted before edge N in IDLE → `grant`/`busy` high after edge N (1-cycle latency).
- Release condition present before edge M → `grant`/`busy` low after edge M.
- Earliest next grant: edge M+1.
- Worst-case wait for a continuously requesting client: 7 other full tenures plus 8 idle cycles.
- `any_req`: zero latency, combinational from `req`.
- Reset deassertion: first arbitration on first rising edge with `rst_n`=1.

## Configuration

- `MY_ARBITER_8_WAY_TIMEOUT_EN` defined: 8-bit tenure counter, cleared on every grant, increments each GRANT cycle. When counter reaches `TIMEOUT_CYCLES`-1 without release, next edge force-releases exactly as a normal release (pointer advances past owner) and pulses `timeout`=1 for one cycle. Normal release at the same edge: `timeout` stays 0.
- Not defined: no counter, no `timeout` port; owner holds grant indefinitely until `done` or `req` drop.

## Test plan

- Reset: `rst_n`=0 with `req`=8'hFF → `grant`=0, `busy`=0, `any_req`=1; release reset → after first edge `grant`=8'b00000001, `grant_id`=0.
- Round-robin: `req`=8'hFF held, pulse `done` each tenure → grants in order 0,1,2,…,7,0 (wrap), one idle cycle between each.
- Sparse requests: `ptr`=3, `req`=8'b00000010 → `grant`=8'b00000010 (wrap past 7); `req`=8'b00010111 with `ptr`=2 → `grant`=8'b00000100.
- Withdrawal and no-preempt: owner 5 granted, raise `req[0]`; hold 4 cycles → `grant` stays 8'b00100000; drop `req[5]` → grant clears next edge, then `grant`=8'b00000001.
- Async reset mid-grant: owner 6 busy, pulse `rst_n` low between edges → `grant`=0, `busy`=0 immediately; after release with `req`=8'hC0 → owner 6 (`ptr`=0).
- Timeout (macro on, `TIMEOUT_CYCLES`=4): owner 2 never asserts `done` → `busy` high exactly 4 cycles, `timeout` pulses once, next grant goes to next requester above 2.
